dma_priority_arbiter: RTL and testbench
=======================================

Name: dma_priority_arbiter

Overview:
- Channel priority resolver and bus-hold sequencer for the 4-channel DMA controller.
- Sits between the DREQ pins, the mask/command registers and the timing-and-control FSM.
- Raises HRQ when any enabled channel requests service. On HLDA it resolves priority with fixed or rotating rules, then drives one-hot DACK.
- Holds the grant until timing-and-control reports end of service, then releases the bus.

Parameters:
- NUM_CH, 4, number of DMA channels; must be 4.
- CH_W, 2, width of the channel index; equals log2(NUM_CH).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET_N  input  1  synchronous active-low reset.
- DREQ  input  NUM_CH  raw channel requests; polarity set by DREQ_SENSE_LOW.
- MASK  input  NUM_CH  mask register; 1 = channel masked.
- CTRL_DISABLE  input  1  command bit 2; 1 = no new requests accepted.
- ROT_PRI  input  1  command bit 4; 1 = rotating priority, 0 = fixed priority.
- DREQ_SENSE_LOW  input  1  1 = DREQ active-low.
- DACK_SENSE_HIGH  input  1  1 = DACK active-high.
- HLDA  input  1  hold acknowledge from the CPU.
- SVC_DONE  input  1  one-cycle pulse from timing-and-control marking end of service (TC, EOP or single-transfer end).
- HRQ  output  1  hold request to the CPU.
- DACK  output  NUM_CH  channel acknowledge.
- ACTIVE_CH  output  CH_W  index of the granted channel.
- CH_VALID  output  1  1 while ACTIVE_CH is valid (GRANT state).
- SVC_START  output  1  one-cycle pulse on entry to GRANT; starts the timing-and-control transfer.

Behaviour:
- Effective request: EREQ[i] = (DREQ[i] ^ DREQ_SENSE_LOW) & ~MASK[i]. The registered one-hot grant vector GNT drives the pins as DACK = GNT ^ {NUM_CH{~DACK_SENSE_HIGH}}; this XOR is combinational.
- Reset (RESET_N low at a CLK edge), all synchronous:
  - state = IDLE, HRQ = 0, GNT = 0 (DACK at its inactive level), ACTIVE_CH = 0, CH_VALID = 0, SVC_START = 0.
  - Rotation pointer LOW_CH = 3, so ch0 has highest priority.
  - Reset mid-service abandons the grant immediately, with no rotation update.
- FSM states IDLE, REQ, GRANT, RELEASE:
  - IDLE: if |EREQ && !CTRL_DISABLE, go to REQ and HRQ becomes 1 on the next edge.
  - REQ:
    - HRQ = 1; wait for HLDA = 1.
    - If EREQ falls to 0 before HLDA, return to IDLE and drop HRQ.
    - On HLDA = 1 with |EREQ: resolve the winner, latch ACTIVE_CH, set GNT = one-hot(winner), CH_VALID = 1, pulse SVC_START for one cycle, and go to GRANT. DACK appears 1 cycle after the HLDA sample.
    - On HLDA = 1 with EREQ = 0: go to RELEASE with no grant.
  - GRANT:
    - Hold GNT, ACTIVE_CH and HRQ.
    - EREQ changes, including the granted channel's DREQ dropping or becoming masked, are ignored.
    - SVC_DONE = 1: clear GNT and CH_VALID, drop HRQ, and go to RELEASE. If ROT_PRI = 1, set LOW_CH = ACTIVE_CH.
    - HLDA = 0 without SVC_DONE is an abort: clear GNT and CH_VALID, drop HRQ, go to RELEASE, and leave LOW_CH unchanged.
    - SVC_DONE and HLDA drop in the same cycle are treated as SVC_DONE.
  - RELEASE: HRQ = 0; wait for HLDA = 0, then go to IDLE. A new request is not raised until the bus is returned (minimum 1 cycle in RELEASE).
- Priority resolution:
  - Fixed (ROT_PRI = 0): the lowest index wins.
  - Rotating (ROT_PRI = 1): the search starts at (LOW_CH + 1) mod 4 and wraps; CH_W-bit arithmetic, natural wrap 3 → 0.
  - ROT_PRI is sampled at resolution time.
  - LOW_CH is only updated under ROT_PRI = 1. Switching to fixed does not reset LOW_CH.
- CTRL_DISABLE = 1 blocks IDLE→REQ only. In-flight REQ and GRANT complete normally.
- At most one DACK bit is ever active. SVC_START is high for exactly one cycle per grant.

Test Plan:
- Fixed priority:
  - Stimulus: ROT_PRI=0, DREQ_SENSE_LOW=0, DACK_SENSE_HIGH=0, DREQ=4'b1010, HLDA raised 2 cycles after HRQ.
  - Required response: HRQ=1 one cycle after DREQ; one cycle after HLDA, ACTIVE_CH=1, DACK=4'b1101, SVC_START pulses once.
- Rotating priority:
  - Stimulus: ROT_PRI=1, DREQ=4'b1111 held, SVC_DONE after each grant, HLDA cycled.
  - Required response: grant order ch0, ch1, ch2, ch3, ch0; LOW_CH tracks the last served channel.
- Mask and polarity:
  - Stimulus: MASK=4'b0001, DREQ_SENSE_LOW=1, DREQ pins=4'b1100 (ch0 and ch1 active).
  - Required response: ch1 granted; ch0 never acknowledged.
- Early withdrawal:
  - Stimulus: DREQ=4'b0100, then DREQ=0 before HLDA.
  - Required response: HRQ drops the next cycle, state returns to IDLE, no DACK and no SVC_START.
- HLDA abort:
  - Stimulus: ch2 in GRANT under ROT_PRI=1, HLDA drops without SVC_DONE.
  - Required response: DACK inactive next cycle, HRQ=0, LOW_CH unchanged (3).
- Reset mid-grant:
  - Stimulus: RESET_N low for 1 cycle during GRANT of ch3.
  - Required response: next cycle HRQ=0, CH_VALID=0, DACK inactive, ACTIVE_CH=0, LOW_CH=3.

Source files
------------

// File: rtl/dma_priority_arbiter_if.sv
// Request/grant bundle between the DMA arbiter and its surroundings.
// Handshake: HRQ is held high from the cycle after an accepted request until
// the grant ends; HLDA is the CPU's answer. DACK/ACTIVE_CH/CH_VALID are stable
// for the whole GRANT state; SVC_START is high for exactly one cycle per grant
// and SVC_DONE is a one-cycle pulse closing it.
interface dma_priority_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0] DREQ;
    logic [NUM_CH-1:0] MASK;
    logic              CTRL_DISABLE;
    logic              ROT_PRI;
    logic              DREQ_SENSE_LOW;
    logic              DACK_SENSE_HIGH;
    logic              HLDA;
    logic              SVC_DONE;
    logic              HRQ;
    logic [NUM_CH-1:0] DACK;
    logic [CH_W-1:0]   ACTIVE_CH;
    logic              CH_VALID;
    logic              SVC_START;
    logic [CH_W-1:0]   LOW_CH_DBG;
    logic [1:0]        STATE_DBG;

    // Environment side: drives requests, configuration and bus handshake.
    modport master (
        output DREQ, MASK, CTRL_DISABLE, ROT_PRI, DREQ_SENSE_LOW,
               DACK_SENSE_HIGH, HLDA, SVC_DONE,
        input  HRQ, DACK, ACTIVE_CH, CH_VALID, SVC_START, LOW_CH_DBG, STATE_DBG
    );

    // Arbiter side.
    modport slave (
        input  DREQ, MASK, CTRL_DISABLE, ROT_PRI, DREQ_SENSE_LOW,
               DACK_SENSE_HIGH, HLDA, SVC_DONE,
        output HRQ, DACK, ACTIVE_CH, CH_VALID, SVC_START, LOW_CH_DBG, STATE_DBG
    );
endinterface

// File: rtl/dma_priority_arbiter.sv
// Channel priority resolver and bus-hold sequencer for a 4-channel DMA.
// Requests raise HRQ; on HLDA one channel is granted (fixed or rotating
// priority) and held until end of service or until the CPU takes the bus back.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input logic                    CLK,
    input logic                    RESET_N,
    dma_priority_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              hrq_q, hrq_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [CH_W-1:0]   active_q, active_d;
    logic              valid_q, valid_d;
    logic              start_q, start_d;
    logic [CH_W-1:0]   low_q, low_d;

    logic [NUM_CH-1:0] ereq;
    logic [CH_W-1:0]   winner;
    logic              found;
    logic [CH_W-1:0]   idx;

    // Effective requests after polarity correction and masking.
    assign ereq = (bus.DREQ ^ {NUM_CH{bus.DREQ_SENSE_LOW}}) & ~bus.MASK;

    // Priority search: from ch0 (fixed) or from the channel after LOW_CH (rotating).
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = bus.ROT_PRI ? (low_q + CH_W'(k + 1)) : CH_W'(k);
            if (!found && ereq[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // State and output registers, all synchronously reset.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            hrq_q    <= 1'b0;
            gnt_q    <= '0;
            active_q <= '0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            low_q    <= CH_W'(NUM_CH - 1);
        end else begin
            state_q  <= state_d;
            hrq_q    <= hrq_d;
            gnt_q    <= gnt_d;
            active_q <= active_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            low_q    <= low_d;
        end
    end

    // Next-state logic: request, grant, hold, and bus return sequencing.
    always_comb begin
        state_d  = state_q;
        hrq_d    = hrq_q;
        gnt_d    = gnt_q;
        active_d = active_q;
        valid_d  = valid_q;
        start_d  = 1'b0;
        low_d    = low_q;
        case (state_q)
            IDLE: begin
                if ((|ereq) && !bus.CTRL_DISABLE) begin
                    state_d = REQ;
                    hrq_d   = 1'b1;
                end
            end
            REQ: begin
                if (bus.HLDA) begin
                    if (|ereq) begin
                        state_d  = GRANT;
                        active_d = winner;
                        gnt_d    = NUM_CH'(1) << winner;
                        valid_d  = 1'b1;
                        start_d  = 1'b1;
                    end else begin
                        // CPU handed over the bus but nobody wants it any more.
                        state_d = RELEASE;
                        hrq_d   = 1'b0;
                    end
                end else if (!(|ereq)) begin
                    state_d = IDLE;
                    hrq_d   = 1'b0;
                end
            end
            GRANT: begin
                // SVC_DONE wins over a simultaneous HLDA drop.
                if (bus.SVC_DONE || !bus.HLDA) begin
                    state_d = RELEASE;
                    hrq_d   = 1'b0;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    if (bus.SVC_DONE && bus.ROT_PRI) begin
                        low_d = active_q;
                    end
                end
            end
            RELEASE: begin
                hrq_d = 1'b0;
                if (!bus.HLDA) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.HRQ        = hrq_q;
    assign bus.DACK       = gnt_q ^ {NUM_CH{~bus.DACK_SENSE_HIGH}};
    assign bus.ACTIVE_CH  = active_q;
    assign bus.CH_VALID   = valid_q;
    assign bus.SVC_START  = start_q;
    assign bus.LOW_CH_DBG = low_q;
    assign bus.STATE_DBG  = state_q;
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: directed scenarios with literal expectations
// followed by randomized traffic checked cycle by cycle against a reference model.
module tb_dma_priority_arbiter;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    dma_priority_arbiter_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

    dma_priority_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Bus phases named after the protocol: 0 idle, 1 hold requested,
    // 2 channel being served, 3 waiting for the CPU to take the bus back.
    int         ph;
    logic       m_hrq;
    logic [3:0] m_gnt;
    int         m_act;
    logic       m_valid;
    logic       m_start;
    int         m_low;
    logic [12:0] exp_q[$];

    function automatic int pick_winner(input logic [3:0] req, input logic rot, input int low);
        int c;
        for (int k = 0; k < NUM_CH; k++) begin
            c = rot ? (low + 1 + k) % NUM_CH : k;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        logic [3:0] req;
        int w;
        req = (bus.DREQ ^ {4{bus.DREQ_SENSE_LOW}}) & ~bus.MASK;
        m_start = 1'b0;
        if (!rst_n) begin
            ph = 0; m_hrq = 0; m_gnt = 0; m_act = 0; m_valid = 0; m_low = 3;
        end else if (ph == 0) begin
            if (req != 0 && !bus.CTRL_DISABLE) begin ph = 1; m_hrq = 1; end
        end else if (ph == 1) begin
            if (bus.HLDA && req != 0) begin
                w = pick_winner(req, bus.ROT_PRI, m_low);
                ph = 2; m_act = w; m_gnt = 4'(1 << w); m_valid = 1; m_start = 1;
            end else if (bus.HLDA) begin
                ph = 3; m_hrq = 0;
            end else if (req == 0) begin
                ph = 0; m_hrq = 0;
            end
        end else if (ph == 2) begin
            if (bus.SVC_DONE) begin
                if (bus.ROT_PRI) m_low = m_act;
                ph = 3; m_hrq = 0; m_gnt = 0; m_valid = 0;
            end else if (!bus.HLDA) begin
                ph = 3; m_hrq = 0; m_gnt = 0; m_valid = 0;
            end
        end else begin
            if (!bus.HLDA) ph = 0;
        end
        exp_q.push_back({m_hrq, m_gnt, 2'(m_act), m_valid, m_start, 2'(m_low), 2'(ph)});
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [12:0] e;
        #1;
        if (exp_q.size() == 0) begin
            check("model_queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("cyc_hrq",   32'(bus.HRQ),        32'(e[12]));
            check("cyc_dack",  32'(bus.DACK),       32'(e[11:8] ^ {4{~bus.DACK_SENSE_HIGH}}));
            check("cyc_act",   32'(bus.ACTIVE_CH),  32'(e[7:6]));
            check("cyc_valid", 32'(bus.CH_VALID),   32'(e[5]));
            check("cyc_start", 32'(bus.SVC_START),  32'(e[4]));
            check("cyc_low",   32'(bus.LOW_CH_DBG), 32'(e[3:2]));
            check("cyc_state", 32'(bus.STATE_DBG),  32'(e[1:0]));
            check("cyc_onehot", 32'($countones(bus.DACK ^ {4{~bus.DACK_SENSE_HIGH}}) <= 1), 32'd1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_hrq();
        int n;
        n = 0;
        while (bus.HRQ !== 1'b1 && n < 20) begin
            cyc(1);
            n++;
        end
        check("wait_hrq", 32'(bus.HRQ), 32'd1);
    endtask

    task automatic serve_rot(input int exp_ch);
        wait_hrq();
        bus.HLDA = 1'b1;
        cyc(1);
        check("rot_valid", 32'(bus.CH_VALID), 32'd1);
        check("rot_ch", 32'(bus.ACTIVE_CH), 32'(exp_ch));
        bus.SVC_DONE = 1'b1;
        cyc(1);
        bus.SVC_DONE = 1'b0;
        check("rot_low", 32'(bus.LOW_CH_DBG), 32'(exp_ch));
        bus.HLDA = 1'b0;
    endtask

    task automatic quiet();
        bus.DREQ = '0; bus.MASK = '0; bus.CTRL_DISABLE = 0; bus.ROT_PRI = 0;
        bus.DREQ_SENSE_LOW = 0; bus.DACK_SENSE_HIGH = 0; bus.HLDA = 0; bus.SVC_DONE = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        quiet();
        cyc(2);
        rst_n = 1'b1;
        check("rst_hrq", 32'(bus.HRQ), 32'd0);
        check("rst_dack", 32'(bus.DACK), 32'hf);
        check("rst_act", 32'(bus.ACTIVE_CH), 32'd0);
        check("rst_valid", 32'(bus.CH_VALID), 32'd0);
        check("rst_low", 32'(bus.LOW_CH_DBG), 32'd3);

        // Fixed priority, ch1 and ch3 requesting.
        bus.DREQ = 4'b1010;
        cyc(1);
        check("fix_hrq", 32'(bus.HRQ), 32'd1);
        cyc(1);
        bus.HLDA = 1'b1;
        cyc(1);
        check("fix_act", 32'(bus.ACTIVE_CH), 32'd1);
        check("fix_dack", 32'(bus.DACK), 32'b1101);
        check("fix_start", 32'(bus.SVC_START), 32'd1);
        bus.DREQ = '0;
        cyc(1);
        check("fix_start_off", 32'(bus.SVC_START), 32'd0);
        check("fix_hold", 32'(bus.DACK), 32'b1101);
        bus.SVC_DONE = 1'b1;
        cyc(1);
        bus.SVC_DONE = 1'b0;
        check("fix_rel_hrq", 32'(bus.HRQ), 32'd0);
        check("fix_rel_dack", 32'(bus.DACK), 32'hf);
        bus.HLDA = 1'b0;
        cyc(2);

        // Rotating priority with all channels requesting.
        bus.ROT_PRI = 1'b1;
        bus.DREQ = 4'b1111;
        serve_rot(0);
        serve_rot(1);
        serve_rot(2);
        serve_rot(3);
        serve_rot(0);
        bus.DREQ = '0;
        cyc(2);

        // Mask and active-low request pins.
        bus.ROT_PRI = 1'b0;
        bus.MASK = 4'b0001;
        bus.DREQ_SENSE_LOW = 1'b1;
        bus.DREQ = 4'b1100;
        wait_hrq();
        bus.HLDA = 1'b1;
        cyc(1);
        check("mask_act", 32'(bus.ACTIVE_CH), 32'd1);
        check("mask_dack", 32'(bus.DACK), 32'b1101);
        bus.SVC_DONE = 1'b1;
        cyc(1);
        bus.SVC_DONE = 1'b0;
        bus.HLDA = 1'b0;
        bus.DREQ = '0;
        bus.DREQ_SENSE_LOW = 1'b0;
        bus.MASK = '0;
        cyc(2);

        // Request withdrawn before HLDA.
        bus.DREQ = 4'b0100;
        cyc(1);
        check("wd_hrq_up", 32'(bus.HRQ), 32'd1);
        bus.DREQ = '0;
        cyc(1);
        check("wd_hrq_down", 32'(bus.HRQ), 32'd0);
        check("wd_state", 32'(bus.STATE_DBG), 32'd0);
        check("wd_dack", 32'(bus.DACK), 32'hf);
        cyc(1);

        // HLDA abort of ch2 under rotating priority, active-high DACK.
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        bus.DACK_SENSE_HIGH = 1'b1;
        bus.ROT_PRI = 1'b1;
        bus.DREQ = 4'b0100;
        wait_hrq();
        bus.HLDA = 1'b1;
        cyc(1);
        check("abort_act", 32'(bus.ACTIVE_CH), 32'd2);
        check("abort_dack_on", 32'(bus.DACK), 32'b0100);
        cyc(1);
        bus.HLDA = 1'b0;
        bus.DREQ = '0;
        cyc(1);
        check("abort_dack_off", 32'(bus.DACK), 32'b0000);
        check("abort_hrq", 32'(bus.HRQ), 32'd0);
        check("abort_low", 32'(bus.LOW_CH_DBG), 32'd3);
        cyc(2);

        // Reset in the middle of serving ch3.
        bus.DACK_SENSE_HIGH = 1'b0;
        bus.ROT_PRI = 1'b0;
        bus.DREQ = 4'b1000;
        wait_hrq();
        bus.HLDA = 1'b1;
        cyc(1);
        check("mrst_act", 32'(bus.ACTIVE_CH), 32'd3);
        rst_n = 1'b0;
        bus.DREQ = '0;
        cyc(1);
        rst_n = 1'b1;
        bus.HLDA = 1'b0;
        check("mrst_hrq", 32'(bus.HRQ), 32'd0);
        check("mrst_valid", 32'(bus.CH_VALID), 32'd0);
        check("mrst_dack", 32'(bus.DACK), 32'hf);
        check("mrst_act0", 32'(bus.ACTIVE_CH), 32'd0);
        check("mrst_low", 32'(bus.LOW_CH_DBG), 32'd3);
        cyc(2);

        // Randomized traffic; the CPU mostly follows HRQ, sometimes misbehaves.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) bus.DREQ = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) bus.MASK = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) bus.DREQ_SENSE_LOW = ~bus.DREQ_SENSE_LOW;
            if ($urandom_range(0, 7) == 0) bus.DACK_SENSE_HIGH = ~bus.DACK_SENSE_HIGH;
            if ($urandom_range(0, 7) == 0) bus.ROT_PRI = ~bus.ROT_PRI;
            bus.CTRL_DISABLE = ($urandom_range(0, 9) == 0);
            if (bus.HRQ) bus.HLDA = ($urandom_range(0, 9) != 0) ? ($urandom_range(0, 2) != 0 || bus.HLDA) : 1'b0;
            else         bus.HLDA = bus.HLDA ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 30) == 0);
            bus.SVC_DONE = m_valid && ($urandom_range(0, 5) == 0);
            rst_n = ($urandom_range(0, 400) != 0);
            cyc(1);
        end

        rst_n = 1'b1;
        quiet();
        cyc(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
